// File: rtl/uart_tx_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo_if
// Brief    : Word handshake between the command translator and uart_tx_fifo.
// Revision : 1.0
// ============================================================================
interface uart_tx_fifo_if #(
    parameter int BITS_N = 8
);
    logic [BITS_N-1:0] data_tx;
    logic              valid;
    logic              tx_ready;

    modport master (
        output data_tx,
        output valid,
        input  tx_ready
    );

    modport slave (
        input  data_tx,
        input  valid,
        output tx_ready
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Brief    : UART transmitter fed from a circular FIFO, back-to-back frames.
// Revision : 1.0
// ============================================================================
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int BITS_N       = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16
) (
    input  wire                           clk,
    input  wire                           reset,
    uart_tx_fifo_if.slave                 tx_if,
    output logic                          uart_tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int c_ptr_w  = $clog2(FIFO_DEPTH);
    localparam int c_cnt_w  = c_ptr_w + 1;
    localparam int c_baud_w = $clog2(CLKS_PER_BIT) + 1;
    localparam int c_bit_w  = $clog2(BITS_N);

    localparam logic [c_baud_w-1:0] c_baud_last = c_baud_w'(CLKS_PER_BIT - 1);
    localparam logic [c_baud_w-1:0] c_baud_one  = c_baud_w'(1);
    localparam logic [c_bit_w-1:0]  c_data_last = c_bit_w'(BITS_N - 1);
    localparam logic [c_bit_w-1:0]  c_stop_last = c_bit_w'(STOP_BITS - 1);
    localparam logic [c_bit_w-1:0]  c_bit_one   = c_bit_w'(1);
    localparam logic [c_ptr_w-1:0]  c_ptr_one   = c_ptr_w'(1);
    localparam logic [c_cnt_w-1:0]  c_cnt_one   = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0]  c_full      = c_cnt_w'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    logic [BITS_N-1:0]   r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0]  r_wr_ptr;
    logic [c_ptr_w-1:0]  r_rd_ptr;
    logic [c_cnt_w-1:0]  r_count;

    state_t              r_state;
    state_t              w_state_n;
    logic [c_baud_w-1:0] r_baud;
    logic [c_baud_w-1:0] w_baud_n;
    logic [c_bit_w-1:0]  r_bit;
    logic [c_bit_w-1:0]  w_bit_n;
    logic [BITS_N-1:0]   r_data;
    logic [BITS_N-1:0]   w_data_n;
    logic                r_tx;
    logic                w_tx_n;

    logic                w_ready;
    logic                w_push;
    logic                w_pop;
    logic                w_bit_end;
    logic                w_par;

    // No look-ahead: a pop in the same cycle never opens the FIFO early.
    assign w_ready        = !reset && (r_count != c_full);
    assign tx_if.tx_ready = w_ready;
    assign w_push         = tx_if.valid && w_ready;
    assign w_bit_end      = (r_baud == c_baud_last);
    assign w_par          = (PARITY == 2) ? ^r_data : ~^r_data;

    assign uart_tx    = r_tx;
    assign fifo_count = r_count;
    assign busy       = (r_state != S_IDLE) || (r_count != '0);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= tx_if.data_tx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_data  <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_n;
            r_baud  <= w_baud_n;
            r_bit   <= w_bit_n;
            r_data  <= w_data_n;
            r_tx    <= w_tx_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_bit_n   = r_bit;
        w_data_n  = r_data;
        w_pop     = 1'b0;
        w_baud_n  = w_bit_end ? '0 : (r_baud + c_baud_one);
        w_tx_n    = 1'b1;

        case (r_state)
            S_IDLE: begin
                w_baud_n = '0;
                if (r_count != '0) begin
                    w_pop     = 1'b1;
                    w_data_n  = r_mem[r_rd_ptr];
                    w_bit_n   = '0;
                    w_state_n = S_START;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_n = S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    if (r_bit == c_data_last) begin
                        w_bit_n   = '0;
                        w_state_n = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        w_bit_n = r_bit + c_bit_one;
                    end
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_bit_n   = '0;
                    w_state_n = S_STOP;
                end
            end
            S_STOP: begin
                // r_bit counts stop bits here; the next word chains straight into START.
                if (w_bit_end) begin
                    if (r_bit == c_stop_last) begin
                        w_bit_n = '0;
                        if (r_count != '0) begin
                            w_pop     = 1'b1;
                            w_data_n  = r_mem[r_rd_ptr];
                            w_state_n = S_START;
                        end else begin
                            w_state_n = S_IDLE;
                        end
                    end else begin
                        w_bit_n = r_bit + c_bit_one;
                    end
                end
            end
            default: begin
                w_state_n = S_IDLE;
                w_baud_n  = '0;
            end
        endcase

        // The line register follows the state being entered so levels align with bit windows.
        case (w_state_n)
            S_START:  w_tx_n = 1'b0;
            S_DATA:   w_tx_n = w_data_n[w_bit_n];
            S_PARITY: w_tx_n = w_par;
            default:  w_tx_n = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_fifo
// Brief    : Directed self-checking bench for uart_tx_fifo (8N1, 8E1, 7O2).
// Revision : 1.0
// ============================================================================
module tb_uart_tx_fifo;

    localparam int CPB = 4;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       tx_n, tx_e, tx_o;
    logic       busy_n, busy_e, busy_o;
    logic [4:0] cnt_n, cnt_e, cnt_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_tx_fifo_if #(.BITS_N(8)) if_n ();
    uart_tx_fifo_if #(.BITS_N(8)) if_e ();
    uart_tx_fifo_if #(.BITS_N(7)) if_o ();

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .BITS_N(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)) dut_n (
        .clk(clk), .reset(reset), .tx_if(if_n.slave),
        .uart_tx(tx_n), .busy(busy_n), .fifo_count(cnt_n)
    );
    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .BITS_N(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16)) dut_e (
        .clk(clk), .reset(reset), .tx_if(if_e.slave),
        .uart_tx(tx_e), .busy(busy_e), .fifo_count(cnt_e)
    );
    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .BITS_N(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(16)) dut_o (
        .clk(clk), .reset(reset), .tx_if(if_o.slave),
        .uart_tx(tx_o), .busy(busy_o), .fifo_count(cnt_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic line(input int sel);
        case (sel)
            0:       return tx_n;
            1:       return tx_e;
            default: return tx_o;
        endcase
    endfunction

    // Waits up to max_wait negedges for a start bit, then samples every cycle of the frame.
    task automatic rx_frame(input int sel, input int max_wait,
                            output logic [8:0] data, output logic par_bit);
        int   nb, np, ns, bad, w;
        logic found;
        nb      = (sel == 2) ? 7 : 8;
        np      = (sel == 0) ? 0 : 1;
        ns      = (sel == 2) ? 2 : 1;
        data    = '0;
        par_bit = 1'b0;
        bad     = 0;
        w       = 0;
        found   = 1'b0;
        while (!found && w < max_wait) begin
            @(negedge clk);
            w++;
            if (line(sel) === 1'b0) found = 1'b1;
        end
        check("start_edge", found, 1);
        if (!found) return;
        for (int i = 1; i < CPB; i++) begin
            @(negedge clk);
            if (line(sel) !== 1'b0) bad++;
        end
        for (int b = 0; b < nb; b++) begin
            @(negedge clk);
            data[b] = line(sel);
            for (int i = 1; i < CPB; i++) begin
                @(negedge clk);
                if (line(sel) !== data[b]) bad++;
            end
        end
        if (np != 0) begin
            @(negedge clk);
            par_bit = line(sel);
            for (int i = 1; i < CPB; i++) begin
                @(negedge clk);
                if (line(sel) !== par_bit) bad++;
            end
        end
        for (int i = 0; i < ns * CPB; i++) begin
            @(negedge clk);
            if (line(sel) !== 1'b1) bad++;
        end
        check("frame_shape", bad, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [8:0] d;
        logic       p;

        if_n.valid = 1'b0; if_n.data_tx = '0;
        if_e.valid = 1'b0; if_e.data_tx = '0;
        if_o.valid = 1'b0; if_o.data_tx = '0;

        // Reset values
        repeat (3) @(negedge clk);
        check("reset_tx", tx_n, 1);
        check("reset_ready", if_n.tx_ready, 0);
        check("reset_busy", busy_n, 0);
        check("reset_count", cnt_n, 0);
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", if_n.tx_ready, 1);

        // Single word 8N1, 0x55
        if_n.data_tx = 8'h55; if_n.valid = 1'b1;
        @(negedge clk);
        if_n.valid = 1'b0;
        check("single_count_k", cnt_n, 1);
        check("single_line_k", tx_n, 1);
        rx_frame(0, 1, d, p);
        check("single_data", d, 9'h055);
        check("single_busy_stop", busy_n, 1);
        @(negedge clk);
        check("single_busy_end", busy_n, 0);
        check("single_idle_line", tx_n, 1);
        check("single_count_end", cnt_n, 0);

        // FIFO fill with valid held high, back-to-back drain
        fork
            begin : fill_push
                int   idx;
                int   acc;
                logic stalled;
                idx = 0; acc = 0; stalled = 1'b0;
                while (idx < 20) begin
                    @(negedge clk);
                    if_n.data_tx = 8'(idx);
                    if_n.valid   = 1'b1;
                    if (if_n.tx_ready) begin
                        idx++;
                        if (!stalled) acc++;
                    end else if (!stalled) begin
                        stalled = 1'b1;
                        check("fill_accepted", acc, 17);
                        check("fill_count_full", cnt_n, 16);
                        check("fill_ready_full", if_n.tx_ready, 0);
                    end
                end
                @(negedge clk);
                if_n.valid = 1'b0;
            end
            begin : fill_rx
                logic [8:0] fd;
                logic       fp;
                for (int i = 0; i < 20; i++) begin
                    rx_frame(0, (i == 0) ? 5 : 1, fd, fp);
                    check("fill_order", fd, i);
                end
            end
        join
        @(negedge clk);
        check("fill_busy_end", busy_n, 0);

        // Even parity 8E1, 0x07
        if_e.data_tx = 8'h07; if_e.valid = 1'b1;
        @(negedge clk);
        if_e.valid = 1'b0;
        rx_frame(1, 1, d, p);
        check("even_data", d, 9'h007);
        check("even_parity", p, 1);
        @(negedge clk);
        check("even_busy_end", busy_e, 0);

        // Odd parity 7O2: 0x7F then 0x03 chained
        fork
            begin : odd_push
                @(negedge clk);
                if_o.data_tx = 7'h7F; if_o.valid = 1'b1;
                @(negedge clk);
                if_o.data_tx = 7'h03;
                @(negedge clk);
                if_o.valid = 1'b0;
            end
            begin : odd_rx
                logic [8:0] od;
                logic       op;
                rx_frame(2, 5, od, op);
                check("odd_data0", od, 9'h07F);
                check("odd_parity0", op, 0);
                rx_frame(2, 1, od, op);
                check("odd_data1", od, 9'h003);
                check("odd_parity1", op, 1);
            end
        join
        @(negedge clk);
        check("odd_busy_end", busy_o, 0);

        // Reset during data bit 3 with 5 words queued
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            if_n.data_tx = 8'h30 + 8'(j);
            if_n.valid   = 1'b1;
            if (j == 5) check("rst_start_low", tx_n, 0);
        end
        @(negedge clk);
        if_n.valid = 1'b0;
        repeat (13) @(negedge clk);
        check("rst_bit3_level", tx_n, 0);
        check("rst_queued", cnt_n, 5);
        reset = 1'b1;
        @(negedge clk);
        check("rst_tx", tx_n, 1);
        check("rst_count", cnt_n, 0);
        check("rst_busy", busy_n, 0);
        check("rst_ready", if_n.tx_ready, 0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_ready_release", if_n.tx_ready, 1);
        check("rst_line_idle", tx_n, 1);
        if_n.data_tx = 8'hA5; if_n.valid = 1'b1;
        @(negedge clk);
        if_n.valid = 1'b0;
        rx_frame(0, 1, d, p);
        check("rst_after_data", d, 9'h0A5);
        @(negedge clk);
        check("rst_after_busy", busy_n, 0);

        // Push on the same edge as the chained pop, with fifo_count = 3
        fork
            begin : sim_push
                for (int j = 0; j < 4; j++) begin
                    @(negedge clk);
                    if_n.data_tx = 8'h41 + 8'(j);
                    if_n.valid   = 1'b1;
                end
                @(negedge clk);
                if_n.valid = 1'b0;
                repeat (37) @(negedge clk);
                check("simul_count_before", cnt_n, 3);
                if_n.data_tx = 8'h45;
                if_n.valid   = 1'b1;
                @(negedge clk);
                if_n.valid = 1'b0;
                check("simul_count_after", cnt_n, 3);
                check("simul_new_start", tx_n, 0);
            end
            begin : sim_rx
                logic [8:0] sd;
                logic       sp;
                for (int i = 0; i < 5; i++) begin
                    rx_frame(0, (i == 0) ? 5 : 1, sd, sp);
                    check("simul_order", sd, 9'h041 + 9'(i));
                end
            end
        join
        @(negedge clk);
        check("simul_busy_end", busy_n, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with a built-in transmit FIFO, configurable frame format (data width, parity, stop bits) and cycle-exact bit timing. It sits between the command translator and the serial pin. It accepts words through a valid/ready handshake and serialises them back-to-back with no idle gap while the FIFO holds data.

## Interface

Parameters:
- CLKS_PER_BIT, 434: clock cycles per UART bit (50 MHz / 115200); legal ≥ 2.
- BITS_N, 8: data bits per frame; legal 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: stop bits per frame; legal 1 or 2.
- FIFO_DEPTH, 16: transmit FIFO entries; power of two, ≥ 2.

Ports:
- clk, input, 1: clock.
- reset, input, 1: reset, synchronous, active-high.
- data_tx, input, BITS_N: word to transmit.
- valid, input, 1: data_tx valid.
- tx_ready, output, 1: FIFO can accept a word.
- uart_tx, output, 1: serial line, idle high, registered.
- busy, output, 1: frame in progress or FIFO non-empty.
- fifo_count, output, $clog2(FIFO_DEPTH)+1: words currently queued.

## Operation

- **Push:** a word is pushed when valid && tx_ready at a rising edge.
- **tx_ready:** equals !full, combinational from count. There is no look-ahead, so a same-cycle pop does not raise tx_ready when full. tx_ready is 0 while reset is high.
- **FIFO:** circular buffer with read/write pointers that wrap modulo FIFO_DEPTH. fifo_count is 0..FIFO_DEPTH.
  - Simultaneous push and pop: count unchanged.
  - Pop when empty: never occurs.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - IDLE: if the FIFO is non-empty, pop into a shift register, clear the bit counter, and go to START. Otherwise stay in IDLE.
  - START: drive 0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: drive bits LSB first, each held CLKS_PER_BIT cycles. After bit BITS_N-1, go to PARITY if PARITY≠0, else to STOP.
  - PARITY: drive 1 cycle-bit.
    - Even: bit = ^data.
    - Odd: bit = ~^data.
  - STOP: drive 1 for STOP_BITS×CLKS_PER_BIT cycles. At the end:
    - If the FIFO is non-empty, pop directly and go to START, with no IDLE cycle.
    - Otherwise go to IDLE.
- **Baud counter:** width $clog2(CLKS_PER_BIT)+1, counts 0..CLKS_PER_BIT-1. It reloads to 0 on every bit boundary. It never free-runs in IDLE, where it is held at 0.
- **busy:** equals (state≠IDLE) || (fifo_count≠0).
- **Reset, including mid-frame:** next edge gives state IDLE, uart_tx 1, FIFO emptied, fifo_count 0, busy 0, and counters 0. A partial frame is abandoned.
  - The line may show a short high-to-low glitch-free truncation. There is no stop-bit completion guarantee.
- **Data latching:** data is captured at the push edge. Later changes on data_tx do not affect queued words.

## Timing

- **Reset values:** uart_tx 1, tx_ready 0 while reset is high and 1 from the first cycle after, busy 0, fifo_count 0.
- **Latency from push to line:** with the block idle and the FIFO empty, a push at edge k gives fifo_count 1 after edge k. At edge k+1 the FSM pops and uart_tx goes low. fifo_count returns to 0 after k+1.
- **Frame length:** (1 + BITS_N + (PARITY≠0) + STOP_BITS) × CLKS_PER_BIT cycles exactly. Each bit level is held exactly CLKS_PER_BIT cycles.
- **Back-to-back frames:** the next start bit begins on the cycle immediately after the last stop-bit cycle, so there is zero gap.
- **Pop timing:** the pop occurs on the edge entering START. From that edge, tx_ready can rise one cycle later at the earliest if the FIFO was full.

## Test plan

- **Single word, 8N1:** CLKS_PER_BIT=4, 8N1; push 0x55 once.
  - Required: uart_tx low 4 cycles after edge k+1, then 1,0,1,0,1,0,1,0 each 4 cycles, then high 4 cycles.
  - Required: busy falls after the stop bit; total 40 cycles.
- **FIFO fill and back-to-back drain:** depth 16; hold valid high with 20 words 0x00..0x13.
  - Required: exactly 17 accepted before the first stall (16 plus 1 popped), and tx_ready low while fifo_count=16.
  - Required: all words emitted in order with zero inter-frame gap.
- **Even parity, 8E1:** push 0x07.
  - Required: parity bit 1; frame 11 bits; stop follows parity.
- **Odd parity with 2 stop bits, 7O2:** push 0x7F.
  - Required: parity bit 0 (seven ones), stop high for 2×CLKS_PER_BIT.
  - Required: next frame starts immediately after.
- **Reset mid-frame:** assert reset during data bit 3 of a frame with 5 words queued.
  - Required: next edge gives uart_tx 1, fifo_count 0, busy 0.
  - Required: after release, pushing 0xA5 transmits a correct full frame.
- **Simultaneous push and pop:** push on the same edge the FSM pops, with fifo_count=3.
  - Required: fifo_count stays 3 and word order is preserved.
